idct8_out_butterfly: RTL and testbench

Inverse of the 8-point forward pre-butterfly: collects one block of eight butterfly-domain samples, y(0..7), and reconstructs the time-domain block x(0..7) with pairwise add/subtract and halve. The input order is y0..y3 as pair sums and y4..y7 as pair differences, the same order the forward stage emits. Sits at the tail of the IDCT pipeline, after the odd/even recombination stages. It is double-buffered, so the next block can be loaded while the current one is streamed out, and `in_ready` provides backpressure.

---
 rtl/idct8_out_butterfly.sv | 152 +++++++++++++++
 tb/tb_idct8_out_butterfly.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/idct8_out_butterfly.sv
// idct8_out_butterfly
//   Tail stage of the IDCT pipeline. Collects a block of eight butterfly-domain
//   samples y0..y7 (y0..y3 pair sums, y4..y7 pair differences) and reconstructs
//   x0..x7 by pairwise add/subtract and halving, saturated to the output width.
//   Two input banks let the next block load while the current one streams out.
//
// Ports
//   clk         clock, rising edge
//   rst_n       synchronous active-low reset
//   in_valid    in_sample valid this cycle
//   in_ready    a sample can be accepted this cycle (combinational)
//   in_sample   signed y(k), y0 first
//   out_valid   out_sample valid (registered)
//   out_sample  signed x(k), x0 first (registered)
//   parity_err  current output block had an odd pair sum (registered)
module idct8_out_butterfly #(
  parameter int DATA_IN_WIDTH  = 16,
  parameter int DATA_OUT_WIDTH = 12
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic signed [DATA_IN_WIDTH-1:0]   in_sample,
  output logic                              out_valid,
  output logic signed [DATA_OUT_WIDTH-1:0]  out_sample,
  output logic                              parity_err
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPUTE = 2'd1,
    S_OUTPUT  = 2'd2
  } state_e;

  localparam int SW = DATA_IN_WIDTH + 1;

  // Saturation bounds expressed at the sum/difference width.
  localparam logic signed [SW-1:0] SAT_MAX =
    {{(SW-DATA_OUT_WIDTH+1){1'b0}}, {(DATA_OUT_WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] SAT_MIN =
    {{(SW-DATA_OUT_WIDTH+1){1'b1}}, {(DATA_OUT_WIDTH-1){1'b0}}};

  state_e                            state_q;
  logic signed [DATA_IN_WIDTH-1:0]   bank_q [2][8];
  logic [1:0]                        bank_full_q;
  logic                              wr_bank_q;
  logic                              rd_bank_q;
  logic [2:0]                        in_count_q;
  logic [2:0]                        out_count_q;
  logic signed [DATA_OUT_WIDTH-1:0]  r_q [8];
  logic signed [DATA_OUT_WIDTH-1:0]  r_d [8];
  logic signed [SW-1:0]              sum_w  [4];
  logic signed [SW-1:0]              diff_w [4];
  logic                              parity_d;
  logic                              accept;
  logic                              out_valid_q;
  logic signed [DATA_OUT_WIDTH-1:0]  out_sample_q;
  logic                              parity_err_q;

  assign in_ready   = !bank_full_q[wr_bank_q];
  assign accept     = in_valid && in_ready;
  assign out_valid  = out_valid_q;
  assign out_sample = out_sample_q;
  assign parity_err = parity_err_q;

  // Floor-halve then clamp into the output range.
  function automatic logic signed [DATA_OUT_WIDTH-1:0] halve_sat(
    input logic signed [SW-1:0] v
  );
    logic signed [SW-1:0] h;
    h = v >>> 1;
    if (h > SAT_MAX)      halve_sat = {1'b0, {(DATA_OUT_WIDTH-1){1'b1}}};
    else if (h < SAT_MIN) halve_sat = {1'b1, {(DATA_OUT_WIDTH-1){1'b0}}};
    else                  halve_sat = h[DATA_OUT_WIDTH-1:0];
  endfunction

  // Pairs (p, 7-p): sum gives x(p), difference gives x(7-p).
  always_comb begin
    parity_d = 1'b0;
    for (int unsigned i = 0; i < 8; i++) r_d[i] = '0;
    for (int unsigned p = 0; p < 4; p++) begin
      sum_w[p]  = $signed({bank_q[rd_bank_q][p[2:0]][DATA_IN_WIDTH-1],
                           bank_q[rd_bank_q][p[2:0]]})
                + $signed({bank_q[rd_bank_q][3'(7-p)][DATA_IN_WIDTH-1],
                           bank_q[rd_bank_q][3'(7-p)]});
      diff_w[p] = $signed({bank_q[rd_bank_q][p[2:0]][DATA_IN_WIDTH-1],
                           bank_q[rd_bank_q][p[2:0]]})
                - $signed({bank_q[rd_bank_q][3'(7-p)][DATA_IN_WIDTH-1],
                           bank_q[rd_bank_q][3'(7-p)]});
      r_d[p[2:0]]   = halve_sat(sum_w[p]);
      r_d[3'(7-p)]  = halve_sat(diff_w[p]);
      parity_d      = parity_d | sum_w[p][0];
    end
  end

  // Bank storage: a full bank is never written, so no clear/write conflict.
  always_ff @(posedge clk) begin
    if (rst_n && accept) bank_q[wr_bank_q][in_count_q] <= in_sample;
  end

  always_ff @(posedge clk) begin
    if (state_q == S_COMPUTE) r_q <= r_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bank_full_q  <= '0;
      wr_bank_q    <= 1'b0;
      rd_bank_q    <= 1'b0;
      in_count_q   <= '0;
      out_count_q  <= '0;
      out_valid_q  <= 1'b0;
      out_sample_q <= '0;
      parity_err_q <= 1'b0;
    end else begin
      // in_count wraps 7->0, which is the clear on the 8th accept.
      if (accept) begin
        in_count_q <= in_count_q + 3'd1;
        if (in_count_q == 3'd7) begin
          bank_full_q[wr_bank_q] <= 1'b1;
          wr_bank_q              <= ~wr_bank_q;
        end
      end

      out_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bank_full_q[rd_bank_q]) state_q <= S_COMPUTE;
        end
        S_COMPUTE: begin
          bank_full_q[rd_bank_q] <= 1'b0;
          rd_bank_q              <= ~rd_bank_q;
          out_count_q            <= '0;
          parity_err_q           <= parity_d;
          state_q                <= S_OUTPUT;
        end
        S_OUTPUT: begin
          out_valid_q  <= 1'b1;
          out_sample_q <= r_q[out_count_q];
          out_count_q  <= out_count_q + 3'd1;
          // rd_bank_q already points at the next bank here.
          if (out_count_q == 3'd7)
            state_q <= bank_full_q[rd_bank_q] ? S_COMPUTE : S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_idct8_out_butterfly.sv
// tb_idct8_out_butterfly
//   Directed-vector bench for idct8_out_butterfly: reset state, round trip,
//   saturation, parity/floor, extreme inputs, backpressure, gapped input and
//   reset during fill/output. Expected outputs are hand-computed tables.
module tb_idct8_out_butterfly;

  localparam int DIW = 16;
  localparam int DOW = 12;

  logic                  clk       = 1'b0;
  logic                  rst_n     = 1'b0;
  logic                  in_valid  = 1'b0;
  logic [DIW-1:0]        in_sample = '0;
  logic                  in_ready;
  logic                  out_valid;
  logic signed [DOW-1:0] out_sample;
  logic                  parity_err;

  idct8_out_butterfly #(
    .DATA_IN_WIDTH (DIW),
    .DATA_OUT_WIDTH(DOW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_sample (in_sample),
    .out_valid (out_valid),
    .out_sample(out_sample),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int oq[$];
  int pq[$];
  int cq[$];
  int stim[$];
  int last_acc = 0;
  bit stall_seen = 1'b0;

  // 0 round trip, 1 sat+, 2 sat-, 3 odd parity, 4 extreme inputs
  string names[5] = '{"rt", "satp", "satn", "par", "ext"};
  int YT[5][8] = '{
    '{-700,  500, -300,  100, -900,  900, -900,  900},
    '{4000,    0,    0,    0,    0,    0,    0, 4000},
    '{-4000,   0,    0,    0,    0,    0,    0, -4000},
    '{   3,    0,    0,    0,    0,    0,    0,    0},
    '{32767,   0,    0,    0,    0,    0,    0, -32768}
  };
  int XT[5][8] = '{
    '{ 100, -200,  300, -400,  500, -600,  700, -800},
    '{2047,    0,    0,    0,    0,    0,    0,    0},
    '{-2048,   0,    0,    0,    0,    0,    0,    0},
    '{   1,    0,    0,    0,    0,    0,    0,    1},
    '{  -1,    0,    0,    0,    0,    0,    0, 2047}
  };
  int PT[5] = '{0, 0, 0, 1, 1};

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      oq.push_back(int'(out_sample));
      pq.push_back(int'(parity_err));
      cq.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic signed [31:0] got,
                     input logic signed [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push_blk(input int k);
    for (int i = 0; i < 8; i++) stim.push_back(YT[k][i]);
  endtask

  task automatic clear_q();
    oq.delete();
    pq.delete();
    cq.delete();
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives every queued sample; last_acc is the edge of the final accept.
  task automatic send(input bit gapped);
    int w;
    for (int i = 0; i < stim.size(); i++) begin
      @(negedge clk);
      if (gapped && i > 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid  = 1'b1;
      in_sample = 16'(stim[i]);
      #1;
      w = 0;
      while (!in_ready && w < 50) begin
        stall_seen = 1'b1;
        @(negedge clk);
        #1;
        w++;
      end
      if (!in_ready) chk("in_ready_timeout", 0, 1);
      last_acc = cyc + 1;
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    stim.delete();
  endtask

  task automatic wait_outs(input int n);
    int t;
    t = 0;
    while (oq.size() < n && t < 300) begin
      @(negedge clk);
      #2;
      t++;
    end
    chk("out_count", oq.size(), n);
  endtask

  task automatic check_blk(input string tag, input int base, input int k,
                           input int lat_ref);
    if (oq.size() < base + 8) return;
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s_x%0d", tag, i), oq[base+i], XT[k][i]);
      chk($sformatf("%s_par%0d", tag, i), pq[base+i], PT[k]);
      if (i > 0) chk($sformatf("%s_nogap%0d", tag, i), cq[base+i] - cq[base], i);
    end
    if (lat_ref >= 0) chk($sformatf("%s_latency", tag), cq[base] - lat_ref, 3);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sample", out_sample, 0);
    chk("rst_parity", parity_err, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;

    // Single isolated blocks with latency from the 8th accept.
    for (int k = 0; k < 5; k++) begin
      push_blk(k);
      send(1'b0);
      lat = last_acc;
      wait_outs(8);
      check_blk(names[k], 0, k, lat);
      idle(3);
      clear_q();
    end

    // Odd-parity block followed directly by an even one.
    push_blk(3);
    push_blk(0);
    send(1'b0);
    wait_outs(16);
    check_blk("par_a", 0, 3, -1);
    check_blk("par_b", 8, 0, -1);
    chk("bubble", cq[8] - cq[7], 2);
    idle(3);
    clear_q();

    // Sustained input: output runs at 8/9, so the banks eventually both fill.
    stall_seen = 1'b0;
    for (int b = 0; b < 10; b++) push_blk(b % 5);
    send(1'b0);
    wait_outs(80);
    chk("bp_stall_seen", stall_seen, 1);
    for (int b = 0; b < 10; b++)
      check_blk($sformatf("bp%0d_%s", b, names[b % 5]), b * 8, b % 5, -1);
    idle(12);
    chk("bp_total", oq.size(), 80);
    clear_q();

    // Gapped input.
    push_blk(0);
    send(1'b1);
    lat = last_acc;
    wait_outs(8);
    check_blk("gap", 0, 0, lat);
    idle(3);
    clear_q();

    // Reset mid-fill, with a stray sample presented during reset.
    for (int i = 0; i < 5; i++) stim.push_back(YT[1][i]);
    send(1'b0);
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    in_sample = 16'd999;
    @(negedge clk);
    chk("rst1_out_valid", out_valid, 0);
    in_valid = 1'b0;
    rst_n    = 1'b1;

    // Reset mid-output.
    push_blk(0);
    send(1'b0);
    wait_outs(3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_out_valid", out_valid, 0);
    rst_n = 1'b1;
    idle(15);
    chk("rst2_lost", oq.size(), 3);
    for (int i = 0; i < 3; i++) chk($sformatf("rst2_x%0d", i), oq[i], XT[0][i]);
    clear_q();

    push_blk(3);
    send(1'b0);
    lat = last_acc;
    wait_outs(8);
    check_blk("post_rst", 0, 3, lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
